// File: rtl/clk_div_pkg.sv
// Shared types and defaults for the clk_div_ctrl slow-clock scheduler.
package clk_div_pkg;

    localparam int DEFAULT_CNT_W     = 8;
    localparam int DEFAULT_DIV_RATIO = 4;
    localparam int MIN_DIV           = 2;

    // STEP is only reachable when CLK_DIV_STEP_EN is defined.
    typedef enum logic [1:0] {
        STOP  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        STEP  = 2'd3
    } state_e;

endpackage

// File: rtl/clk_div_core.sv
// Period counter with registered div_clk/tick, both derived from the
// next counter value so they stay aligned with the count and glitch-free.
module clk_div_core
    import clk_div_pkg::*;
#(
    parameter int CNT_W = DEFAULT_CNT_W
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             i_run,
    input  logic             i_run_nxt,
    input  logic [CNT_W-1:0] i_cur_div,
    input  logic [CNT_W-1:0] i_div_nxt,
    output logic             o_boundary,
    output logic             o_div_clk,
    output logic             o_tick
);

    logic [CNT_W-1:0] r_cnt;
    logic             r_div_clk;
    logic             r_tick;
    logic             w_at_end;
    logic [CNT_W-1:0] w_cnt_nxt;

    // Wrap at N-1; a fresh period (start or after a stop) always begins at 0.
    always_comb begin
        w_at_end  = (r_cnt == i_cur_div - CNT_W'(1));
        w_cnt_nxt = '0;
        if (i_run && i_run_nxt && !w_at_end) begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
        end
    end

    // Counter and outputs; outputs use the ratio in effect for the next cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt     <= '0;
            r_div_clk <= 1'b0;
            r_tick    <= 1'b0;
        end else begin
            r_cnt     <= w_cnt_nxt;
            r_div_clk <= i_run_nxt && (w_cnt_nxt >= (i_div_nxt >> 1));
            r_tick    <= i_run_nxt && (w_cnt_nxt == i_div_nxt - CNT_W'(1));
        end
    end

    assign o_boundary = i_run && w_at_end;
    assign o_div_clk  = r_div_clk;
    assign o_tick     = r_tick;

endmodule

// File: rtl/clk_div_ctrl.sv
// Clock-enable / divided-clock scheduler: run FSM, config handshake and
// pending-ratio register. Ratio changes land only on period boundaries.
// Optional single-period step mode: define CLK_DIV_STEP_EN.
module clk_div_ctrl
    import clk_div_pkg::*;
#(
    parameter int CNT_W       = DEFAULT_CNT_W,
    parameter int DEFAULT_DIV = DEFAULT_DIV_RATIO
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
`ifdef CLK_DIV_STEP_EN
    input  logic             step,
`endif
    input  logic             cfg_valid,
    input  logic [CNT_W-1:0] cfg_div,
    output logic             cfg_ready,
    output logic             cfg_err,
    output logic             div_clk,
    output logic             tick,
    output logic             running,
    output logic [CNT_W-1:0] cur_div
);

    state_e           r_state;
    state_e           w_state_nxt;
    logic [CNT_W-1:0] r_cur_div;
    logic [CNT_W-1:0] r_pend_div;
    logic             r_pending;
    logic             r_cfg_err;

    logic             w_boundary;
    logic             w_run;
    logic             w_run_nxt;
    logic             w_accept;
    logic             w_bad;
    logic             w_apply;
    logic [CNT_W-1:0] w_div_nxt;

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= STOP;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state: a started period always runs to its boundary.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            STOP: begin
                if (en) begin
                    w_state_nxt = RUN;
                end
`ifdef CLK_DIV_STEP_EN
                else if (step) begin
                    w_state_nxt = STEP;
                end
`endif
            end
            RUN: begin
                if (!en) begin
                    w_state_nxt = w_boundary ? STOP : DRAIN;
                end
            end
            DRAIN: begin
                if (en) begin
                    w_state_nxt = RUN;
                end else if (w_boundary) begin
                    w_state_nxt = STOP;
                end
            end
`ifdef CLK_DIV_STEP_EN
            STEP: begin
                if (w_boundary) begin
                    w_state_nxt = STOP;
                end
            end
`endif
            default: w_state_nxt = STOP;
        endcase
    end

    // Handshake decode; a pending ratio is applied when idle or on a boundary.
    always_comb begin
        w_run     = (r_state != STOP);
        w_run_nxt = (w_state_nxt != STOP);
        w_accept  = cfg_valid && !r_pending;
        w_bad     = (cfg_div < CNT_W'(MIN_DIV));
        w_apply   = r_pending && (!w_run || w_boundary);
        w_div_nxt = w_apply ? r_pend_div : r_cur_div;
    end

    // Config registers: pending slot, ratio in effect, reject pulse.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cur_div  <= CNT_W'(DEFAULT_DIV);
            r_pend_div <= '0;
            r_pending  <= 1'b0;
            r_cfg_err  <= 1'b0;
        end else begin
            r_cfg_err <= w_accept && w_bad;
            if (w_apply) begin
                r_cur_div <= r_pend_div;
                r_pending <= 1'b0;
            end else if (w_accept && !w_bad) begin
                r_pend_div <= cfg_div;
                r_pending  <= 1'b1;
            end
        end
    end

    // Status outputs.
    always_comb begin
        running   = w_run;
        cfg_ready = !r_pending;
        cfg_err   = r_cfg_err;
        cur_div   = r_cur_div;
    end

    clk_div_core #(
        .CNT_W (CNT_W)
    ) u_core (
        .clk        (clk),
        .reset_n    (reset_n),
        .i_run      (w_run),
        .i_run_nxt  (w_run_nxt),
        .i_cur_div  (r_cur_div),
        .i_div_nxt  (w_div_nxt),
        .o_boundary (w_boundary),
        .o_div_clk  (div_clk),
        .o_tick     (tick)
    );

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Directed bench for clk_div_ctrl with a period-level reference model.
module tb_clk_div_ctrl;

    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic             en = 1'b0;
`ifdef CLK_DIV_STEP_EN
    logic             step = 1'b0;
`endif
    logic             cfg_valid = 1'b0;
    logic [CNT_W-1:0] cfg_div = '0;
    logic             cfg_ready;
    logic             cfg_err;
    logic             div_clk;
    logic             tick;
    logic             running;
    logic [CNT_W-1:0] cur_div;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    clk_div_ctrl #(
        .CNT_W       (CNT_W),
        .DEFAULT_DIV (4)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .en        (en),
`ifdef CLK_DIV_STEP_EN
        .step      (step),
`endif
        .cfg_valid (cfg_valid),
        .cfg_div   (cfg_div),
        .cfg_ready (cfg_ready),
        .cfg_err   (cfg_err),
        .div_clk   (div_clk),
        .tick      (tick),
        .running   (running),
        .cur_div   (cur_div)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    // Reference model: a period, once started, always completes; at its end
    // it continues only if en is high (and not a single step). Position k
    // within an N-cycle period defines div_clk and tick directly.
    bit m_act = 0, m_one = 0, m_pend = 0, m_err = 0;
    int m_k = 0, m_n = 4, m_pn = 0;
    bit m_bnd, m_acc, m_app;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_act = 0; m_one = 0; m_pend = 0; m_err = 0;
            m_k = 0; m_n = 4; m_pn = 0;
        end else begin
            m_bnd = m_act && (m_k == m_n - 1);
            m_acc = cfg_valid && !m_pend;
            m_app = m_pend && (!m_act || m_bnd);
            m_err = m_acc && (cfg_div < 2);
            if (!m_act) begin
                if (en) begin
                    m_act = 1; m_one = 0; m_k = 0;
                end
`ifdef CLK_DIV_STEP_EN
                else if (step) begin
                    m_act = 1; m_one = 1; m_k = 0;
                end
`endif
            end else if (m_bnd) begin
                if (en && !m_one) m_k = 0;
                else begin m_act = 0; m_k = 0; end
            end else begin
                m_k++;
            end
            if (m_app) begin
                m_n = m_pn; m_pend = 0;
            end else if (m_acc && cfg_div >= 2) begin
                m_pn = 32'(cfg_div); m_pend = 1;
            end
        end
    end

    // Every cycle: DUT against model.
    always @(negedge clk) begin
        check("m_div_clk", 32'(div_clk), 32'(m_act && (m_k >= m_n / 2)));
        check("m_tick", 32'(tick), 32'(m_act && (m_k == m_n - 1)));
        check("m_running", 32'(running), 32'(m_act));
        check("m_cur_div", 32'(cur_div), m_n);
        check("m_cfg_ready", 32'(cfg_ready), 32'(!m_pend));
        check("m_cfg_err", 32'(cfg_err), 32'(m_err));
    end

    int pat4[4] = '{0, 0, 1, 1};
    int pat6[6] = '{0, 0, 0, 1, 1, 1};
    int nticks, nrun;

    initial begin
        repeat (2) @(negedge clk);
        check("rst_div_clk", 32'(div_clk), 0);
        check("rst_tick", 32'(tick), 0);
        check("rst_running", 32'(running), 0);
        check("rst_cur_div", 32'(cur_div), 4);
        check("rst_cfg_ready", 32'(cfg_ready), 1);
        check("rst_cfg_err", 32'(cfg_err), 0);
        reset_n = 1'b1;

        // Start at default N=4
        @(negedge clk); en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("n4_div_clk", 32'(div_clk), pat4[i % 4]);
            check("n4_tick", 32'(tick), 32'(i % 4 == 3));
            check("n4_running", 32'(running), 1);
        end

        // Ratio 6 offered mid-period (cnt=1)
        @(negedge clk);
        @(negedge clk); cfg_valid = 1'b1; cfg_div = 8'd6;
        @(negedge clk); cfg_valid = 1'b0;
        check("n6_ready_low", 32'(cfg_ready), 0);
        check("n6_old_div", 32'(cur_div), 4);
        @(negedge clk);
        check("n6_old_tick", 32'(tick), 1);
        check("n6_ready_low2", 32'(cfg_ready), 0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("n6_div_clk", 32'(div_clk), pat6[i]);
            check("n6_tick", 32'(tick), 32'(i == 5));
            check("n6_cur_div", 32'(cur_div), 6);
            if (i == 0) check("n6_ready_back", 32'(cfg_ready), 1);
        end

        // Rejected ratios 1 and 0
        cfg_valid = 1'b1; cfg_div = 8'd1;
        @(negedge clk); cfg_valid = 1'b0;
        check("err1_pulse", 32'(cfg_err), 1);
        check("err1_ready", 32'(cfg_ready), 1);
        check("err1_cur_div", 32'(cur_div), 6);
        @(negedge clk);
        check("err1_end", 32'(cfg_err), 0);
        cfg_valid = 1'b1; cfg_div = 8'd0;
        @(negedge clk); cfg_valid = 1'b0;
        check("err0_pulse", 32'(cfg_err), 1);
        @(negedge clk);
        check("err0_end", 32'(cfg_err), 0);
        check("err0_cur_div", 32'(cur_div), 6);

        // Move to N=5 (offered at cnt=3 of the 6-period)
        cfg_valid = 1'b1; cfg_div = 8'd5;
        @(negedge clk); cfg_valid = 1'b0;
        check("n5_ready_low", 32'(cfg_ready), 0);
        @(negedge clk);
        check("n5_last_tick", 32'(tick), 1);
        @(negedge clk);
        check("n5_cur_div", 32'(cur_div), 5);
        check("n5_ready", 32'(cfg_ready), 1);
        // Drop en at cnt=1: period drains to completion
        @(negedge clk); en = 1'b0;
        @(negedge clk);
        check("drain_running2", 32'(running), 1);
        @(negedge clk);
        check("drain_div_clk3", 32'(div_clk), 1);
        @(negedge clk);
        check("drain_tick4", 32'(tick), 1);
        check("drain_running4", 32'(running), 1);
        @(negedge clk);
        check("drain_stop_running", 32'(running), 0);
        check("drain_stop_div_clk", 32'(div_clk), 0);
        check("drain_stop_tick", 32'(tick), 0);

        // Restart, drop at cnt=1, reassert at cnt=3
        en = 1'b1;
        @(negedge clk);
        check("restart_cnt0_run", 32'(running), 1);
        @(negedge clk); en = 1'b0;
        @(negedge clk);
        @(negedge clk); en = 1'b1;
        @(negedge clk);
        check("reassert_tick", 32'(tick), 1);
        @(negedge clk);
        check("reassert_nogap_run", 32'(running), 1);
        check("reassert_nogap_div", 32'(div_clk), 0);

        // Reset at cnt=2 with ratio 8 pending
        cfg_valid = 1'b1; cfg_div = 8'd8;
        @(negedge clk); cfg_valid = 1'b0;
        check("p8_ready_low", 32'(cfg_ready), 0);
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("arst_running", 32'(running), 0);
        check("arst_div_clk", 32'(div_clk), 0);
        check("arst_tick", 32'(tick), 0);
        check("arst_cur_div", 32'(cur_div), 4);
        check("arst_ready", 32'(cfg_ready), 1);
        @(negedge clk); reset_n = 1'b1; en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("arst_pend_gone", 32'(cur_div), 4);
            check("arst_idle", 32'(running), 0);
        end

        // Apply in STOP: the cycle after accept
        cfg_valid = 1'b1; cfg_div = 8'd3;
        @(negedge clk); cfg_valid = 1'b0;
        check("stop_ready_low", 32'(cfg_ready), 0);
        check("stop_old_div", 32'(cur_div), 4);
        @(negedge clk);
        check("stop_applied", 32'(cur_div), 3);
        check("stop_ready_back", 32'(cfg_ready), 1);

        // Ratio accepted on a boundary waits a full period
        en = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("n3_div_clk1", 32'(div_clk), 1);
        @(negedge clk);
        check("n3_tick", 32'(tick), 1);
        cfg_valid = 1'b1; cfg_div = 8'd2;
        @(negedge clk); cfg_valid = 1'b0;
        check("bnd_wait_div", 32'(cur_div), 3);
        check("bnd_ready_low", 32'(cfg_ready), 0);
        @(negedge clk);
        @(negedge clk);
        check("bnd_full_tick", 32'(tick), 1);
        check("bnd_full_div", 32'(cur_div), 3);
        @(negedge clk);
        check("n2_cur_div", 32'(cur_div), 2);
        check("n2_ready", 32'(cfg_ready), 1);
        check("n2_div_clk0", 32'(div_clk), 0);
        @(negedge clk);
        check("n2_div_clk1", 32'(div_clk), 1);
        check("n2_tick", 32'(tick), 1);
        en = 1'b0;
        @(negedge clk);
        check("n2_stopped", 32'(running), 0);

`ifdef CLK_DIV_STEP_EN
        // Single step at N=3
        cfg_valid = 1'b1; cfg_div = 8'd3;
        @(negedge clk); cfg_valid = 1'b0;
        @(negedge clk);
        check("step_div_ready", 32'(cur_div), 3);
        step = 1'b1;
        @(negedge clk); step = 1'b0;
        check("step_running", 32'(running), 1);
        check("step_div_clk0", 32'(div_clk), 0);
        nticks = 0; nrun = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            nticks += int'(tick);
            nrun += int'(running);
        end
        check("step_one_tick", nticks, 1);
        check("step_run_cycles", nrun, 2);
`endif

        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
